// File: rtl/call_initiator_if.sv
// Bundles the operand stream, the start/done callee bus and the result
// stream of call_initiator. The block drives through "master". The
// environment (the feeding logic, the callee and the result consumer)
// drives through "slave".
interface call_initiator_if #(
  parameter int WIDTH = 32
);
  // Operand stream (valid/ready)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  // Start/done call bus to the generated callee
  logic             callee_start;
  logic [WIDTH-1:0] callee_a;
  logic [WIDTH-1:0] callee_b;
  logic [WIDTH-1:0] callee_result;
  logic             callee_done;

  // Result pulse and status
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_timeout;
  logic             error;
  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, callee_result, callee_done,
    output in_ready, callee_start, callee_a, callee_b,
           out_valid, out_result, out_timeout, error, busy
  );

  modport slave (
    output in_valid, in_a, in_b, callee_result, callee_done,
    input  in_ready, callee_start, callee_a, callee_b,
           out_valid, out_result, out_timeout, error, busy
  );
endinterface

// File: rtl/call_initiator.sv
// Caller-side driver for the start/done call protocol. Each accepted
// operand pair becomes one call. The block waits for done to fall and then
// rise again, so the stale done=1 left by the previous call is never taken
// as completion. The result is returned as a one-cycle out_valid pulse.
// A watchdog aborts a call that does not complete. An aborted call sets a
// sticky error, and the block then refuses new calls until reset.
// The interface instance must be built with the same WIDTH as this module.
module call_initiator #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64   // must be >= 4
) (
  input  logic              clk,
  input  logic              reset,
  call_initiator_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_CLR,
    WAIT_SET
  } state_t;

  // One spare bit above clog2 so the saturating timer can pass TIMEOUT-1.
  localparam int            TW         = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_next;
  logic             timer_last;
  logic             in_ready;
  logic             accept;
  logic             exit_cond;

  logic             callee_start;
  logic [WIDTH-1:0] callee_a;
  logic [WIDTH-1:0] callee_b;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_timeout;
  logic             error;

  // The handshake ignores in_valid, so in_ready cannot form a
  // combinational loop with an upstream source that waits for ready.
  assign in_ready   = (state == IDLE) && !error;
  assign accept     = bus.in_valid && in_ready;

  // The timer saturates and never wraps. A wrap could hide an expired call.
  assign timer_next = (timer == TIMER_MAX) ? timer : timer + 1'b1;
  assign timer_last = (timer == TIMER_LAST);

  // WAIT_CLR leaves when done falls. WAIT_SET leaves when done rises.
  assign exit_cond  = (state == WAIT_CLR) ? !bus.callee_done : bus.callee_done;

  // Call sequencer: state, timer, callee operands and the registered result.
  // NOTE: every register here uses <= so all of them update together from
  // this cycle's values. A blocking assignment would let later statements
  // see the new value and change the timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      callee_start <= 1'b0;
      callee_a     <= '0;
      callee_b     <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_timeout  <= 1'b0;
      error        <= 1'b0;
    end else begin
      // NOTE: the pulse outputs default low here, so out_valid lasts one
      // cycle unless a branch below sets it again.
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            callee_a     <= bus.in_a;
            callee_b     <= bus.in_b;
            callee_start <= 1'b1;
            timer        <= '0;
            state        <= START;
          end
        end

        START: begin
          callee_start <= 1'b0;
          state        <= WAIT_CLR;
        end

        WAIT_CLR, WAIT_SET: begin
          timer <= timer_next;
          if (exit_cond) begin
            // Completion wins over a timeout that expires on the same cycle.
            if (state == WAIT_CLR) begin
              state <= WAIT_SET;
            end else begin
              out_result <= bus.callee_result;
              out_valid  <= 1'b1;
              state      <= IDLE;
            end
          end else if (timer_last) begin
            out_valid   <= 1'b1;
            out_timeout <= 1'b1;
            out_result  <= '0;
            error       <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.callee_start = callee_start;
  assign bus.callee_a     = callee_a;
  assign bus.callee_b     = callee_b;
  assign bus.out_valid    = out_valid;
  assign bus.out_result   = out_result;
  assign bus.out_timeout  = out_timeout;
  assign bus.error        = error;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_call_initiator.sv
// Directed bench for call_initiator. A behavioural (a+b)^2 callee is
// attached. It can delay clearing done, or it can never raise done at all.
module tb_call_initiator;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  call_initiator_if #(.WIDTH(WIDTH)) bus ();

  call_initiator #(.WIDTH(WIDTH), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural callee. It samples start. After clear_delay extra cycles it
  // latches the operands and clears done. On the next cycle it raises done
  // with (a+b)^2 truncated to WIDTH.
  logic [1:0]       cst;
  int               cdly;
  int               clear_delay;
  bit               never_done;
  logic [WIDTH-1:0] la, lb;

  always @(posedge clk) begin
    if (reset) begin
      cst               <= 2'd0;
      cdly              <= 0;
      la                <= '0;
      lb                <= '0;
      bus.callee_done   <= 1'b0;
      bus.callee_result <= '0;
    end else begin
      case (cst)
        2'd0: if (bus.callee_start) begin
          cst  <= 2'd1;
          cdly <= clear_delay;
        end
        2'd1: if (cdly != 0) begin
          cdly <= cdly - 1;
        end else begin
          la              <= bus.callee_a;
          lb              <= bus.callee_b;
          bus.callee_done <= 1'b0;
          cst             <= 2'd2;
        end
        2'd2: begin
          if (!never_done) begin
            bus.callee_result <= (la + lb) * (la + lb);
            bus.callee_done   <= 1'b1;
          end
          cst <= 2'd0;
        end
        default: cst <= 2'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                       input logic [WIDTH-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair for a single cycle. The block must be ready for it.
  task automatic accept(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    check({tag, "_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_start"}, bus.callee_start, 1'b1);
  endtask

  // Count the edges after acceptance until out_valid, with a bounded wait.
  // Also count the extra callee_start cycles seen along the way.
  task automatic wait_out(input string tag, output int lat, output int starts);
    lat    = 0;
    starts = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.callee_start) starts++;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_seen"}, (lat != 0), 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"},   bus.callee_start, 1'b0);
    check({tag, "_a"},       bus.callee_a, '0);
    check({tag, "_b"},       bus.callee_b, '0);
    check({tag, "_ov"},      bus.out_valid, 1'b0);
    check({tag, "_res"},     bus.out_result, '0);
    check({tag, "_tmo"},     bus.out_timeout, 1'b0);
    check({tag, "_err"},     bus.error, 1'b0);
    check({tag, "_busy"},    bus.busy, 1'b0);
    check({tag, "_inready"}, bus.in_ready, 1'b1);
  endtask

  logic [WIDTH-1:0] pa [3];
  logic [WIDTH-1:0] pb [3];
  logic [WIDTH-1:0] pexp [3];

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  lat, starts, idx, got, last_ov;
    bit  acc, prev_ready, ov_seen;

    clear_delay  = 0;
    never_done   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    reset        = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state, then a single call of 3,4, which should return 49.
    check_reset_state("por");
    accept("c34", 32'd3, 32'd4);
    check("c34_busy", bus.busy, 1'b1);
    check("c34_opa", bus.callee_a, 32'd3);
    wait_out("c34", lat, starts);
    check("c34_latency", lat, 4);
    check("c34_start_pulse", starts, 0);
    check("c34_result", bus.out_result, 32'd49);
    check("c34_timeout", bus.out_timeout, 1'b0);

    // Back-to-back pairs with in_valid held high.
    pa   = '{32'd1, 32'd5, 32'd0};
    pb   = '{32'd2, 32'd5, 32'd7};
    pexp = '{32'd9, 32'd100, 32'd49};
    idx  = 0;
    got  = 0;
    last_ov      = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = pa[0];
    bus.in_b     = pb[0];
    prev_ready   = bus.in_ready;
    for (int cyc = 1; cyc <= 60 && got < 3; cyc++) begin
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.in_a = pa[idx];
          bus.in_b = pb[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        check($sformatf("b2b_result%0d", got), bus.out_result, pexp[got]);
        check($sformatf("b2b_ready_rise%0d", got), {prev_ready, bus.in_ready}, 2'b01);
        if (got > 0) check($sformatf("b2b_spacing%0d", got), cyc - last_ov, 5);
        last_ov = cyc;
        got++;
      end
      prev_ready = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    check("b2b_count", got, 3);

    // Stale done=1, and the callee clears it 3 cycles late.
    clear_delay = 3;
    accept("slow", 32'd2, 32'd3);
    wait_out("slow", lat, starts);
    check("slow_latency", lat, 7);
    check("slow_result", bus.out_result, 32'd25);
    check("slow_timeout", bus.out_timeout, 1'b0);
    clear_delay = 0;

    // Callee never raises done: the watchdog fires 8 cycles into WAIT_CLR.
    never_done = 1'b1;
    accept("tmo", 32'd1, 32'd1);
    wait_out("tmo", lat, starts);
    check("tmo_latency", lat, 9);
    check("tmo_flag", bus.out_timeout, 1'b1);
    check("tmo_result", bus.out_result, '0);
    check("tmo_error", bus.error, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tmo_blocked_ready%0d", i), bus.in_ready, 1'b0);
      check($sformatf("tmo_blocked_busy%0d", i), bus.busy, 1'b0);
    end
    bus.in_valid = 1'b0;
    never_done   = 1'b0;

    // Reset clears the sticky error.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_clear", bus.error, 1'b0);
    check("err_clear_ready", bus.in_ready, 1'b1);

    // Reset asserted while in WAIT_SET (two edges after acceptance).
    accept("rst", 32'd6, 32'd1);
    tick();
    tick();
    check("rst_busy_before", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_state("midrst");
    reset   = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("midrst_no_stray_ov", ov_seen, 1'b0);
    accept("c22", 32'd2, 32'd2);
    wait_out("c22", lat, starts);
    check("c22_latency", lat, 4);
    check("c22_result", bus.out_result, 32'd16);

    // All-ones operands: the result is truncated to 32 bits, giving 4.
    accept("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("max_opb", bus.callee_b, 32'hFFFF_FFFF);
    wait_out("max", lat, starts);
    check("max_result", bus.out_result, 32'd4);
    check("max_timeout", bus.out_timeout, 1'b0);
    tick();
    check("max_pulse_end", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
